// File: rtl/assoc_cache.sv
// Fully-associative read cache with a single outstanding miss.
// The full request address is the tag. Victim choice is the lowest invalid
// line, otherwise FIFO round-robin (REPL=0) or true LRU (REPL=1).
module assoc_cache #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int ENTRIES = 4,
  parameter int REPL    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              flush,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_hit,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
);

  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(ENTRIES - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] MREQ  = 2'd1;
  localparam logic [1:0] MWAIT = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]        state;
  logic [ENTRIES-1:0] valid;
  logic [ADDR_W-1:0] line_tag  [ENTRIES];
  logic [DATA_W-1:0] line_data [ENTRIES];
  logic [IDX_W-1:0]  fifo_ptr;
  // Recency rank per line: 0 = least recent, IDX_MAX = most recent.
  logic [IDX_W-1:0]  rank [ENTRIES];

  logic              lookup_hit;
  logic [IDX_W-1:0]  hit_idx;
  logic              has_invalid;
  logic [IDX_W-1:0]  invalid_idx;
  logic [IDX_W-1:0]  lru_idx;
  logic [IDX_W-1:0]  victim;
  logic              accept;
  logic              fill;
  logic              flush_now;
  logic              touch_en;
  logic [IDX_W-1:0]  touch_idx;

  assign req_ready = (state == IDLE) && !flush;
  assign accept    = req_valid && req_ready;
  assign flush_now = (state == IDLE) && flush;
  assign fill      = (state == MWAIT) && mem_rsp_valid;
  assign touch_en  = (accept && lookup_hit) || fill;
  assign touch_idx = fill ? victim : hit_idx;

  // Tag match of the incoming address against all valid lines.
  always_comb begin
    lookup_hit = 1'b0;
    hit_idx    = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (!lookup_hit && valid[i] && (line_tag[i] == req_addr)) begin
        lookup_hit = 1'b1;
        hit_idx    = IDX_W'(i);
      end
    end
  end

  // Victim selection from the line state of the current cycle.
  always_comb begin
    has_invalid = 1'b0;
    invalid_idx = '0;
    lru_idx     = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (!has_invalid && !valid[i]) begin
        has_invalid = 1'b1;
        invalid_idx = IDX_W'(i);
      end
      if (rank[i] == '0) begin
        lru_idx = IDX_W'(i);
      end
    end
    if (has_invalid) begin
      victim = invalid_idx;
    end else if (REPL == 1) begin
      victim = lru_idx;
    end else begin
      victim = fifo_ptr;
    end
  end

  // Control FSM, valid bits, FIFO pointer, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      valid         <= '0;
      fifo_ptr      <= '0;
      rsp_valid     <= 1'b0;
      rsp_hit       <= 1'b0;
      rsp_data      <= '0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      hit_count     <= '0;
      miss_count    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (flush) begin
            valid    <= '0;
            fifo_ptr <= '0;
          end else if (req_valid) begin
            if (lookup_hit) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_hit   <= 1'b1;
              rsp_data  <= line_data[hit_idx];
              if (hit_count != '1) hit_count <= hit_count + 16'd1;
            end else begin
              state         <= MREQ;
              mem_req_valid <= 1'b1;
              mem_req_addr  <= req_addr;
              if (miss_count != '1) miss_count <= miss_count + 16'd1;
            end
          end
        end
        MREQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= MWAIT;
          end
        end
        MWAIT: begin
          if (mem_rsp_valid) begin
            valid[victim] <= 1'b1;
            if (!has_invalid) begin
              fifo_ptr <= (fifo_ptr == IDX_MAX) ? '0 : fifo_ptr + IDX_W'(1);
            end
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_hit   <= 1'b0;
            rsp_data  <= mem_rsp_data;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  // Line tag/data storage; mem_req_addr still holds the captured miss address.
  always_ff @(posedge clk) begin
    if (fill) begin
      line_tag[victim]  <= mem_req_addr;
      line_data[victim] <= mem_rsp_data;
    end
  end

  // Recency ranks: the touched line becomes most recent, newer lines age by one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned j = 0; j < ENTRIES; j++) rank[j] <= IDX_W'(j);
    end else if (flush_now) begin
      for (int unsigned j = 0; j < ENTRIES; j++) rank[j] <= IDX_W'(j);
    end else if (touch_en) begin
      for (int unsigned j = 0; j < ENTRIES; j++) begin
        if (IDX_W'(j) == touch_idx) begin
          rank[j] <= IDX_MAX;
        end else if (rank[j] > rank[touch_idx]) begin
          rank[j] <= rank[j] - IDX_W'(1);
        end
      end
    end
  end

endmodule
